// File: rtl/accum_stage_pkg.sv
// Shared definitions for the accumulate stage: FSM state encoding and a
// constant clog2 used to size the accumulator and word counter.
package accum_stage_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/accum_word_cnt.sv
// Word counter for the accumulate stage: counts accepted words and flags the
// final word of a group (count == COUNT-1) so the next transfer completes it.
module accum_word_cnt
  import accum_stage_pkg::*;
#(
  parameter  int COUNT = 4,
  localparam int CNT_W = clog2(COUNT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // clr wins over load1, which wins over inc
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CNT_W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/accum_stage.sv
// Accumulates COUNT upstream {carry,sum} words into one result word, with a
// valid/ready handshake on both sides and a synchronous clear.
module accum_stage
  import accum_stage_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int COUNT = 4,
  localparam int ACC_W = WIDTH + 1 + clog2(COUNT),
  localparam int CNT_W = clog2(COUNT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt
);

  state_e           state_d, state_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [ACC_W-1:0] word;
  logic             xfer;
  logic             cnt_clr, cnt_load1, cnt_inc, cnt_tc;

  assign word     = {{(ACC_W - WIDTH - 1){1'b0}}, in_carry, in_sum};
  // Ready in DONE only when the result leaves this cycle, so no bubble between groups
  assign in_ready = !clear && ((state_q == ACC) || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    if (clear) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ACC: begin
          if (xfer) begin
            acc_d   = acc_q + word;
            cnt_inc = 1'b1;
            if (cnt_tc) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACC;
            if (xfer) begin
              acc_d     = word;
              cnt_load1 = 1'b1;
            end else begin
              acc_d   = '0;
              cnt_clr = 1'b1;
            end
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  accum_word_cnt #(.COUNT(COUNT)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (out_cnt),
    .tc    (cnt_tc)
  );

  assign out_valid = (state_q == DONE);
  assign out_acc   = acc_q;

endmodule

// File: tb/tb_accum_stage.sv
// Directed table-driven bench for accum_stage (WIDTH=8, COUNT=4) plus
// hand-written reset sequences.
module tb_accum_stage;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_sum;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_acc;
  logic [2:0]  out_cnt;

  int errors = 0;
  int checks = 0;

  accum_stage #(.WIDTH(8), .COUNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        vld;
    logic        carry;
    logic [7:0]  sum;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_vld;
    logic [10:0] exp_acc;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic v, input logic ca, input logic [7:0] s,
                     input logic o, input logic er, input logic ev,
                     input logic [10:0] ea, input logic [2:0] ec);
    vec_t t;
    t.clr = c; t.vld = v; t.carry = ca; t.sum = s; t.ordy = o;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_acc = ea; t.exp_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic ca,
                       input logic [7:0] s, input logic o);
    clear = c; in_valid = v; in_carry = ca; in_sum = s; out_ready = o;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    //   clr vld car sum  ordy  rdy vld acc   cnt
    add(0, 1, 0, 8'd255, 1,  1, 0, 11'd255,  3'd1);
    add(0, 1, 1, 8'd255, 1,  1, 0, 11'd766,  3'd2);
    add(0, 1, 0, 8'd1,   1,  1, 0, 11'd767,  3'd3);
    add(0, 1, 1, 8'd0,   1,  1, 1, 11'd1023, 3'd4);
    for (int k = 0; k < 5; k++)
      add(0, 1, 0, 8'd9, 0,  0, 1, 11'd1023, 3'd4);
    add(0, 1, 0, 8'd7,   1,  1, 0, 11'd7,    3'd1);
    add(0, 1, 0, 8'd13,  1,  1, 0, 11'd20,   3'd2);
    add(1, 1, 0, 8'd5,   1,  0, 0, 11'd0,    3'd0);
    add(0, 1, 0, 8'd1,   1,  1, 0, 11'd1,    3'd1);
    add(0, 1, 0, 8'd1,   1,  1, 0, 11'd2,    3'd2);
    add(0, 1, 0, 8'd1,   1,  1, 0, 11'd3,    3'd3);
    add(0, 1, 0, 8'd1,   1,  1, 1, 11'd4,    3'd4);
    add(0, 0, 0, 8'd0,   1,  1, 0, 11'd0,    3'd0);
    add(0, 1, 1, 8'd255, 1,  1, 0, 11'd511,  3'd1);
    add(0, 1, 1, 8'd255, 1,  1, 0, 11'd1022, 3'd2);
    add(0, 1, 1, 8'd255, 1,  1, 0, 11'd1533, 3'd3);
    add(0, 1, 1, 8'd255, 1,  1, 1, 11'd2044, 3'd4);
    add(1, 1, 0, 8'd3,   1,  0, 0, 11'd0,    3'd0);
    add(0, 0, 0, 8'd0,   1,  1, 0, 11'd0,    3'd0);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc",   32'(out_acc),   32'd0);
    chk("rst_out_cnt",   32'(out_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].clr, vecs[i].vld, vecs[i].carry, vecs[i].sum, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("v%0d_out_acc", i),   32'(out_acc),   32'(vecs[i].exp_acc));
      chk($sformatf("v%0d_out_cnt", i),   32'(out_cnt),   32'(vecs[i].exp_cnt));
    end

    // Async reset while holding a result in DONE
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 8'd2, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("done_pre_rst_valid", 32'(out_valid), 32'd1);
    chk("done_pre_rst_acc",   32'(out_acc),   32'd8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_cnt",   32'(out_cnt),   32'd0);
    chk("async_rst_acc",   32'(out_acc),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("async_rel_in_ready", 32'(in_ready), 32'd1);

    // Reset in mid-accumulation discards the partial total
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 8'd50, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    #1;
    chk("mid_pre_rst_acc", 32'(out_acc), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", 32'(out_acc), 32'd0);
    chk("mid_rst_cnt", 32'(out_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'd6, 1'b1);
    @(posedge clk);
    #1;
    chk("post_rst_acc", 32'(out_acc), 32'd6);
    chk("post_rst_cnt", 32'(out_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
